ni_spike_scheduler: RTL and testbench

Arbitrates spike events from several neuron-core requesters into one network-interface stage. It classifies each spike as local (stays in this accelerator) or remote (injected into the NoC), and dispatches it on the matching output channel. Round-robin arbitration is combined with credit-based flow control toward the router. Sits between the neuron cores' spike outputs and the local-delivery / router-injection ports of the accelerator tile.

---
 rtl/ni_spike_scheduler.sv | 125 ++++++++++++
 tb/tb_ni_spike_scheduler.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ni_spike_scheduler.sv
// Spike network-interface stage: round-robin arbitration over neuron-core requesters,
// local/remote classification, a one-entry output register and NoC credit tracking.
module ni_spike_scheduler #(
  parameter int                      NUM_BITS_ADDR = 12,
  parameter int                      NUM_BITS_ACC  = 4,
  parameter logic [NUM_BITS_ACC-1:0] LOCAL_ACC_ID  = 4'h3,
  parameter int                      NUM_REQ       = 4,
  parameter int                      NOC_CREDITS   = 4
) (
  input  logic                                  CLK,
  input  logic                                  RESET_N,
  input  logic [NUM_REQ-1:0]                    req_valid,
  input  logic [NUM_REQ*NUM_BITS_ADDR-1:0]      req_addr,
  output logic [NUM_REQ-1:0]                    req_ready,
  output logic                                  local_valid,
  output logic [NUM_BITS_ADDR-NUM_BITS_ACC-1:0] local_addr,
  input  logic                                  local_ready,
  output logic                                  noc_valid,
  output logic [NUM_BITS_ADDR-1:0]              noc_addr,
  input  logic                                  noc_ready,
  input  logic                                  credit_return,
  output logic [3:0]                            credit_count,
  output logic                                  credit_err,
  output logic [15:0]                           cnt_local,
  output logic [15:0]                           cnt_noc
);

  localparam int         PTR_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [3:0] CREDIT_MAX = 4'(NOC_CREDITS);

  typedef enum logic [1:0] {EMPTY, FULL_LOCAL, FULL_NOC} state_t;

  state_t                   state, state_next;
  logic [NUM_BITS_ADDR-1:0] stage_addr, stage_addr_next;
  logic [PTR_W-1:0]         rr_ptr, rr_ptr_next;
  logic [PTR_W-1:0]         winner, idx;
  logic [NUM_REQ-1:0]       stays, eligible;
  logic                     local_hs, noc_hs, drain, can_load, credit_avail, found, transfer;

  assign local_hs = (state == FULL_LOCAL) && local_ready;
  assign noc_hs   = (state == FULL_NOC) && noc_ready;
  assign drain    = local_hs || noc_hs;
  assign can_load = RESET_N && ((state == EMPTY) || drain);
  // A staged remote spike has already reserved one credit that is not yet spent.
  assign credit_avail = (state == FULL_NOC) ? (credit_count > 4'd1) : (credit_count != 4'd0);

  always_comb begin
    stays    = '0;
    eligible = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      stays[i]    = (req_addr[i*NUM_BITS_ADDR + NUM_BITS_ADDR - 1 -: NUM_BITS_ACC] == LOCAL_ACC_ID);
      eligible[i] = req_valid[i] && (stays[i] || credit_avail);
    end
  end

  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = PTR_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (!found && eligible[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  assign transfer = can_load && found;

  always_comb begin
    req_ready = '0;
    if (transfer) req_ready[winner] = 1'b1;
  end

  always_comb begin
    state_next      = state;
    stage_addr_next = stage_addr;
    rr_ptr_next     = rr_ptr;
    if (transfer) begin
      state_next      = stays[winner] ? FULL_LOCAL : FULL_NOC;
      stage_addr_next = req_addr[int'(winner)*NUM_BITS_ADDR +: NUM_BITS_ADDR];
      rr_ptr_next     = winner;
    end else if (drain) begin
      state_next = EMPTY;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state      <= EMPTY;
      stage_addr <= '0;
      rr_ptr     <= PTR_W'(NUM_REQ - 1);
    end else begin
      state      <= state_next;
      stage_addr <= stage_addr_next;
      rr_ptr     <= rr_ptr_next;
    end
  end

  // A return and a send in the same cycle cancel; a return with nothing outstanding is an error.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      credit_count <= CREDIT_MAX;
      credit_err   <= 1'b0;
      cnt_local    <= '0;
      cnt_noc      <= '0;
    end else begin
      if (noc_hs && !credit_return) begin
        credit_count <= credit_count - 4'd1;
      end else if (credit_return && !noc_hs) begin
        if (credit_count == CREDIT_MAX) credit_err <= 1'b1;
        else                            credit_count <= credit_count + 4'd1;
      end
      if (local_hs) cnt_local <= cnt_local + 16'd1;
      if (noc_hs)   cnt_noc   <= cnt_noc + 16'd1;
    end
  end

  assign local_valid = (state == FULL_LOCAL);
  assign noc_valid   = (state == FULL_NOC);
  assign local_addr  = stage_addr[NUM_BITS_ADDR-NUM_BITS_ACC-1:0];
  assign noc_addr    = stage_addr;

endmodule

// File: tb/tb_ni_spike_scheduler.sv
// Bench for ni_spike_scheduler: directed scenarios with literal expectations, then random
// traffic compared every cycle against a transaction-level model of the scheduler.
module tb_ni_spike_scheduler;

  localparam int NUM_REQ     = 4;
  localparam int NOC_CREDITS = 4;

  logic        CLK;
  logic        RESET_N;
  logic [3:0]  req_valid;
  logic [47:0] req_addr;
  logic [3:0]  req_ready;
  logic        local_valid;
  logic [7:0]  local_addr;
  logic        local_ready;
  logic        noc_valid;
  logic [11:0] noc_addr;
  logic        noc_ready;
  logic        credit_return;
  logic [3:0]  credit_count;
  logic        credit_err;
  logic [15:0] cnt_local;
  logic [15:0] cnt_noc;

  int checks = 0;
  int errors = 0;

  // Model state: the spike currently held by the output stage plus bookkeeping.
  logic        m_valid;
  logic        m_local;
  logic [11:0] m_addr;
  int          m_credits;
  int          m_last;
  int          m_nl;
  int          m_nn;
  logic        m_err;
  int          m_grant;

  ni_spike_scheduler dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .local_valid(local_valid), .local_addr(local_addr), .local_ready(local_ready),
    .noc_valid(noc_valid), .noc_addr(noc_addr), .noc_ready(noc_ready),
    .credit_return(credit_return), .credit_count(credit_count), .credit_err(credit_err),
    .cnt_local(cnt_local), .cnt_noc(cnt_noc)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [11:0] addr_of(input int i);
    return req_addr[i*12 +: 12];
  endfunction

  function automatic logic is_local(input logic [11:0] a);
    return a[11:8] == 4'h3;
  endfunction

  // Every cycle: compare outputs with the model, then advance the model over the coming edge.
  always @(negedge CLK) begin
    logic       drained, room, spent;
    logic [3:0] exp_ready;
    int         free, w, i;
    if (!RESET_N) begin
      m_valid = 1'b0; m_local = 1'b0; m_addr = '0; m_credits = NOC_CREDITS;
      m_last = NUM_REQ - 1; m_nl = 0; m_nn = 0; m_err = 1'b0; m_grant = -1;
    end
    check_output("local_valid", 32'(local_valid), 32'(m_valid && m_local));
    check_output("noc_valid", 32'(noc_valid), 32'(m_valid && !m_local));
    if (m_valid && m_local)  check_output("local_addr", 32'(local_addr), 32'(m_addr[7:0]));
    if (m_valid && !m_local) check_output("noc_addr", 32'(noc_addr), 32'(m_addr));
    check_output("credit_count", 32'(credit_count), 32'(m_credits));
    check_output("credit_err", 32'(credit_err), 32'(m_err));
    check_output("cnt_local", 32'(cnt_local), 32'(16'(m_nl)));
    check_output("cnt_noc", 32'(cnt_noc), 32'(16'(m_nn)));

    drained = RESET_N && m_valid && (m_local ? local_ready : noc_ready);
    room    = !m_valid || drained;
    free    = m_credits - ((m_valid && !m_local) ? 1 : 0);
    w = -1;
    for (int k = 1; k <= NUM_REQ; k++) begin
      i = (m_last + k) % NUM_REQ;
      if (w < 0 && req_valid[i] && (is_local(addr_of(i)) || free > 0)) w = i;
    end
    exp_ready = (RESET_N && room && w >= 0) ? 4'(1 << w) : 4'b0000;
    check_output("req_ready", 32'(req_ready), 32'(exp_ready));

    m_grant = -1;
    if (RESET_N) begin
      spent = 1'b0;
      if (drained) begin
        if (m_local) m_nl++;
        else begin m_nn++; spent = 1'b1; end
      end
      if (credit_return && !spent && m_credits == NOC_CREDITS) m_err = 1'b1;
      else m_credits = m_credits - int'(spent) + int'(credit_return);
      if (room && w >= 0) begin
        m_valid = 1'b1; m_addr = addr_of(w); m_local = is_local(m_addr);
        m_last = w; m_grant = w;
      end else if (drained) begin
        m_valid = 1'b0;
      end
    end
  end

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic sample();
    @(negedge CLK);
  endtask

  task automatic apply_stimulus(input logic [3:0] v, input logic lr, input logic nr, input logic cr);
    next_cycle();
    req_valid = v; local_ready = lr; noc_ready = nr; credit_return = cr;
  endtask

  task automatic set_addr(input int i, input logic [11:0] a);
    req_addr[i*12 +: 12] = a;
  endtask

  initial begin
    logic        pending [NUM_REQ];
    logic [11:0] paddr   [NUM_REQ];
    RESET_N = 1'b0; req_valid = '0; req_addr = '0;
    local_ready = 1'b0; noc_ready = 1'b0; credit_return = 1'b0;
    repeat (2) sample();
    check_output("rst credit_count", 32'(credit_count), 32'd4);
    check_output("rst req_ready", 32'(req_ready), 32'd0);
    check_output("rst valids", 32'({local_valid, noc_valid}), 32'd0);
    check_output("rst counters", 32'({cnt_local, cnt_noc}), 32'd0);
    next_cycle();
    RESET_N = 1'b1;

    // Round-robin, all local, sink always ready: grants 0,1,2,3,0 back to back.
    apply_stimulus(4'b1111, 1'b1, 1'b1, 1'b0);
    set_addr(0, 12'h300); set_addr(1, 12'h311); set_addr(2, 12'h322); set_addr(3, 12'h333);
    for (int k = 0; k < 5; k++) begin
      sample();
      check_output("rr grant", 32'(req_ready), 32'(4'b0001 << (k % 4)));
      if (k > 0) begin
        check_output("rr local_valid", 32'(local_valid), 32'd1);
        check_output("rr local_addr", 32'(local_addr), 32'(8'h11 * ((k - 1) % 4)));
      end
      if (k < 4) next_cycle();
    end
    apply_stimulus(4'b0000, 1'b1, 1'b1, 1'b0);
    sample();
    check_output("rr last addr", 32'(local_addr), 32'h00);
    apply_stimulus(4'b0000, 1'b1, 1'b1, 1'b0);
    sample();
    check_output("rr cnt_local", 32'(cnt_local), 32'd5);

    // Single local spike.
    apply_stimulus(4'b0001, 1'b1, 1'b1, 1'b0);
    set_addr(0, 12'h3A5);
    sample();
    check_output("local grant", 32'(req_ready), 32'b0001);
    apply_stimulus(4'b0000, 1'b1, 1'b1, 1'b0);
    sample();
    check_output("local valid", 32'(local_valid), 32'd1);
    check_output("local addr", 32'(local_addr), 32'hA5);
    apply_stimulus(4'b0000, 1'b1, 1'b1, 1'b0);
    sample();
    check_output("local cnt", 32'(cnt_local), 32'd6);
    check_output("local empty", 32'(local_valid), 32'd0);

    // Single remote spike consumes a credit; one return restores it.
    apply_stimulus(4'b0001, 1'b1, 1'b1, 1'b0);
    set_addr(0, 12'h1A5);
    sample();
    check_output("noc grant", 32'(req_ready), 32'b0001);
    apply_stimulus(4'b0000, 1'b1, 1'b1, 1'b0);
    sample();
    check_output("noc valid", 32'(noc_valid), 32'd1);
    check_output("noc addr", 32'(noc_addr), 32'h1A5);
    apply_stimulus(4'b0000, 1'b1, 1'b1, 1'b0);
    sample();
    check_output("noc credits", 32'(credit_count), 32'd3);
    apply_stimulus(4'b0000, 1'b1, 1'b1, 1'b1);
    apply_stimulus(4'b0000, 1'b1, 1'b1, 1'b0);
    sample();
    check_output("noc credit back", 32'(credit_count), 32'd4);

    // Credit exhaustion: four remote spikes, then requester 0 starves while a local one passes.
    apply_stimulus(4'b0001, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      sample();
      check_output("exh grant", 32'(req_ready), 32'b0001);
      next_cycle();
    end
    sample();
    check_output("exh blocked", 32'(req_ready), 32'd0);
    next_cycle();
    sample();
    check_output("exh credits", 32'(credit_count), 32'd0);
    check_output("exh cnt_noc", 32'(cnt_noc), 32'd5);
    apply_stimulus(4'b0011, 1'b1, 1'b1, 1'b0);
    set_addr(1, 12'h310);
    sample();
    check_output("exh local grant", 32'(req_ready), 32'b0010);
    apply_stimulus(4'b0001, 1'b1, 1'b1, 1'b1);
    sample();
    check_output("exh local addr", 32'(local_addr), 32'h10);
    check_output("exh still blocked", 32'(req_ready), 32'd0);
    apply_stimulus(4'b0001, 1'b1, 1'b1, 1'b0);
    sample();
    check_output("exh regrant", 32'(req_ready), 32'b0001);
    apply_stimulus(4'b0000, 1'b1, 1'b1, 1'b0);
    apply_stimulus(4'b0000, 1'b1, 1'b1, 1'b0);
    sample();
    check_output("exh cnt_noc after", 32'(cnt_noc), 32'd6);
    repeat (3) apply_stimulus(4'b0000, 1'b1, 1'b1, 1'b1);
    apply_stimulus(4'b0000, 1'b1, 1'b1, 1'b0);
    sample();
    check_output("exh refill", 32'(credit_count), 32'd3);

    // Backpressure, then drain with a simultaneous credit return and a same-cycle reload.
    apply_stimulus(4'b1100, 1'b1, 1'b0, 1'b0);
    set_addr(2, 12'h5C7); set_addr(3, 12'h3EE);
    sample();
    check_output("bp grant", 32'(req_ready), 32'b0100);
    apply_stimulus(4'b1000, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      sample();
      check_output("bp addr stable", 32'(noc_addr), 32'h5C7);
      check_output("bp no grant", 32'(req_ready), 32'd0);
      if (k < 2) next_cycle();
    end
    apply_stimulus(4'b1000, 1'b1, 1'b1, 1'b1);
    sample();
    check_output("bp reload grant", 32'(req_ready), 32'b1000);
    apply_stimulus(4'b0000, 1'b1, 1'b1, 1'b0);
    sample();
    check_output("bp credits same", 32'(credit_count), 32'd3);
    check_output("bp local addr", 32'(local_addr), 32'hEE);

    // Over-return sets the sticky error without moving the count.
    apply_stimulus(4'b0000, 1'b1, 1'b1, 1'b1);
    apply_stimulus(4'b0000, 1'b1, 1'b1, 1'b1);
    sample();
    check_output("err before", 32'(credit_err), 32'd0);
    apply_stimulus(4'b0000, 1'b1, 1'b1, 1'b0);
    sample();
    check_output("err set", 32'(credit_err), 32'd1);
    check_output("err count", 32'(credit_count), 32'd4);

    // Reset while a local spike is staged.
    apply_stimulus(4'b0001, 1'b0, 1'b1, 1'b0);
    set_addr(0, 12'h3A5);
    apply_stimulus(4'b0000, 1'b0, 1'b1, 1'b0);
    sample();
    check_output("mid valid before", 32'(local_valid), 32'd1);
    #1;
    RESET_N = 1'b0;
    #1;
    check_output("mid valid dropped", 32'(local_valid), 32'd0);
    check_output("mid err cleared", 32'(credit_err), 32'd0);
    check_output("mid counters", 32'({cnt_local, cnt_noc}), 32'd0);
    next_cycle();
    next_cycle();
    RESET_N = 1'b1;

    // Random traffic; each requester holds its spike until the model says it was granted.
    for (int i = 0; i < NUM_REQ; i++) begin pending[i] = 1'b0; paddr[i] = '0; end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      next_cycle();
      for (int i = 0; i < NUM_REQ; i++) begin
        if (m_grant == i) pending[i] = 1'b0;
        if (!pending[i] && ($urandom % 3 == 0)) begin
          pending[i] = 1'b1;
          paddr[i][11:8] = ($urandom % 2 == 0) ? 4'h3 : 4'($urandom_range(0, 15));
          paddr[i][7:0]  = 8'($urandom);
        end
        req_valid[i] = pending[i];
        req_addr[i*12 +: 12] = paddr[i];
      end
      local_ready   = ($urandom % 4) != 0;
      noc_ready     = ($urandom % 3) != 0;
      credit_return = (m_credits < NOC_CREDITS) && ($urandom % 4 == 0);
    end
    apply_stimulus(4'b0000, 1'b1, 1'b1, 1'b0);
    repeat (3) sample();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
